// File: rtl/video_timing_analyser.sv
// video_timing_analyser
//   Measures raster geometry (active/total pixels and lines) of a video
//   stream. The stream's pixel clock is oversampled by clk. A lock flag
//   asserts once LOCK_FRAMES consecutive frames measure identically.
//   Optional feature macro: VIDEO_TIMING_SYNC_WIDTH_EN adds the hsync_width
//   and vsync_width measurements. Both are also part of the lock comparison.
module video_timing_analyser #(
    parameter int COUNT_WIDTH  = 12,
    parameter int LOCK_FRAMES  = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vid_clk,
    input  logic                   vid_hsync_n,
    input  logic                   vid_vsync_n,
    input  logic                   vid_hblank_n,
    input  logic                   vid_vblank_n,
    output logic [COUNT_WIDTH-1:0] width,
    output logic [COUNT_WIDTH-1:0] height,
    output logic [COUNT_WIDTH-1:0] h_total,
    output logic [COUNT_WIDTH-1:0] v_total,
`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
    output logic [COUNT_WIDTH-1:0] hsync_width,
    output logic [COUNT_WIDTH-1:0] vsync_width,
`endif
    output logic                   locked,
    output logic                   frame_start,
    output logic                   line_start,
    output logic                   overflow
);

    localparam int CW     = COUNT_WIDTH;
`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
    localparam int NSET   = 6;
`else
    localparam int NSET   = 4;
`endif
    localparam int SET_W  = NSET * CW;
    localparam int LOCK_N = (LOCK_FRAMES < 2) ? 2 : LOCK_FRAMES;
    localparam int MW     = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_N);

    typedef enum logic [1:0] {S_UNLOCKED, S_ACQUIRE, S_LOCKED} state_t;

    function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
        f_inc = (&v) ? v : v + ONE;
    endfunction

    // synchroniser chain, bit order {vid_clk, hsync_n, vsync_n, hblank_n, vblank_n}
    logic [4:0] r_sync [SYNC_STAGES];
    logic       r_vclk_prev, r_hs_prev, r_vs_prev;
    logic       w_vclk, w_hs, w_vs, w_hb, w_vb;
    logic       w_pix_ce, w_line_edge, w_frame_edge;

    logic [CW-1:0] r_h_cnt, r_a_cnt, r_h_meas, r_w_meas, r_v_cnt, r_act;
`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
    logic [CW-1:0] r_hsw_cnt, r_hsw_meas, r_vsw_cnt;
`endif
    logic [TIMEOUT_BITS-1:0] r_wd;
    logic                    w_wd_fire;
    logic                    r_sat, w_sat_hit, w_ovf_new;

    state_t        r_state, w_state_nxt;
    logic [MW-1:0] r_match, w_match_nxt;
    logic          r_locked, w_locked_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic          r_discard, w_discard_nxt;
    logic [SET_W-1:0] r_set, w_set_nxt, w_set_new;
    logic          r_frame_start, r_line_start;

    // shift all five inputs through SYNC_STAGES flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= {vid_clk, vid_hsync_n, vid_vsync_n, vid_hblank_n, vid_vblank_n};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_vclk = r_sync[SYNC_STAGES-1][4];
    assign w_hs   = r_sync[SYNC_STAGES-1][3];
    assign w_vs   = r_sync[SYNC_STAGES-1][2];
    assign w_hb   = r_sync[SYNC_STAGES-1][1];
    assign w_vb   = r_sync[SYNC_STAGES-1][0];

    assign w_pix_ce     = w_vclk & ~r_vclk_prev;
    assign w_line_edge  = w_pix_ce & r_hs_prev & ~w_hs;
    assign w_frame_edge = w_pix_ce & r_vs_prev & ~w_vs;

    // previous sampled values; sync history only advances on pix_ce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vclk_prev <= 1'b0;
            r_hs_prev   <= 1'b0;
            r_vs_prev   <= 1'b0;
        end else begin
            r_vclk_prev <= w_vclk;
            if (w_pix_ce) begin
                r_hs_prev <= w_hs;
                r_vs_prev <= w_vs;
            end
        end
    end

    // watchdog: saturates at all-ones and keeps firing until pixels resume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_wd <= '0;
        else if (w_pix_ce)  r_wd <= '0;
        else if (!(&r_wd))  r_wd <= r_wd + TIMEOUT_BITS'(1);
    end

    assign w_wd_fire = ~w_pix_ce & (&r_wd);

    // pixel and active-pixel counters, latched per line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_wd_fire) begin
            r_h_cnt  <= '0;
            r_a_cnt  <= '0;
            r_h_meas <= '0;
            r_w_meas <= '0;
        end else if (w_line_edge) begin
            r_h_meas <= r_h_cnt;
            r_w_meas <= r_a_cnt;
            r_h_cnt  <= ONE;
            r_a_cnt  <= w_hb ? ONE : '0;
        end else if (w_pix_ce) begin
            r_h_cnt <= f_inc(r_h_cnt);
            if (w_hb) r_a_cnt <= f_inc(r_a_cnt);
        end
    end

    // line and active-line counters; a coincident line edge starts the new frame at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_wd_fire) begin
            r_v_cnt <= '0;
            r_act   <= '0;
        end else if (w_frame_edge) begin
            r_v_cnt <= w_line_edge ? ONE : '0;
            r_act   <= (w_line_edge && w_vb) ? ONE : '0;
        end else if (w_line_edge) begin
            r_v_cnt <= f_inc(r_v_cnt);
            if (w_vb) r_act <= f_inc(r_act);
        end
    end

`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
    // sync pulse widths: pixels of hsync low per line, line edges of vsync low per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_wd_fire) begin
            r_hsw_cnt  <= '0;
            r_hsw_meas <= '0;
            r_vsw_cnt  <= '0;
        end else begin
            if (w_line_edge) begin
                r_hsw_meas <= r_hsw_cnt;
                r_hsw_cnt  <= ONE;
            end else if (w_pix_ce && !w_hs) begin
                r_hsw_cnt <= f_inc(r_hsw_cnt);
            end
            if (w_frame_edge)
                r_vsw_cnt <= (w_line_edge && !w_vs) ? ONE : '0;
            else if (w_line_edge && !w_vs)
                r_vsw_cnt <= f_inc(r_vsw_cnt);
        end
    end

    assign w_sat_hit = (w_pix_ce && !w_line_edge && !w_hs && (&r_hsw_cnt)) ||
                       (w_line_edge && !w_vs && (&r_vsw_cnt)) ||
                       (w_pix_ce && !w_line_edge && (&r_h_cnt)) ||
                       (w_pix_ce && !w_line_edge && w_hb && (&r_a_cnt)) ||
                       (w_line_edge && (&r_v_cnt)) ||
                       (w_line_edge && w_vb && (&r_act));
    assign w_set_new = {w_line_edge ? r_a_cnt : r_w_meas, r_act,
                        w_line_edge ? r_h_cnt : r_h_meas, r_v_cnt,
                        w_line_edge ? r_hsw_cnt : r_hsw_meas, r_vsw_cnt};
`else
    assign w_sat_hit = (w_pix_ce && !w_line_edge && (&r_h_cnt)) ||
                       (w_pix_ce && !w_line_edge && w_hb && (&r_a_cnt)) ||
                       (w_line_edge && (&r_v_cnt)) ||
                       (w_line_edge && w_vb && (&r_act));
    assign w_set_new = {w_line_edge ? r_a_cnt : r_w_meas, r_act,
                        w_line_edge ? r_h_cnt : r_h_meas, r_v_cnt};
`endif

    assign w_ovf_new = r_sat | w_sat_hit;

    // per-frame saturation flag, handed to overflow at each frame edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_wd_fire)  r_sat <= 1'b0;
        else if (w_frame_edge)    r_sat <= 1'b0;
        else if (w_sat_hit)       r_sat <= 1'b1;
    end

    // lock FSM state, outputs and start pulses; all update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_UNLOCKED;
            r_match       <= '0;
            r_locked      <= 1'b0;
            r_ovf         <= 1'b0;
            r_discard     <= 1'b0;
            r_set         <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_match       <= w_match_nxt;
            r_locked      <= w_locked_nxt;
            r_ovf         <= w_ovf_nxt;
            r_discard     <= w_discard_nxt;
            r_set         <= w_set_nxt;
            r_frame_start <= w_frame_edge;
            r_line_start  <= w_line_edge;
        end
    end

    // lock decision on the frame-edge pix_ce; the output set doubles as the stored set
    always_comb begin
        w_state_nxt   = r_state;
        w_match_nxt   = r_match;
        w_locked_nxt  = r_locked;
        w_ovf_nxt     = r_ovf;
        w_discard_nxt = r_discard;
        w_set_nxt     = r_set;
        if (w_wd_fire) begin
            w_state_nxt   = S_UNLOCKED;
            w_match_nxt   = '0;
            w_locked_nxt  = 1'b0;
            w_discard_nxt = 1'b1;
        end else if (w_frame_edge) begin
            if (r_discard) begin
                w_discard_nxt = 1'b0;
            end else begin
                w_set_nxt = w_set_new;
                w_ovf_nxt = w_ovf_new;
                case (r_state)
                    S_UNLOCKED: begin
                        w_match_nxt = MW'(1);
                        w_state_nxt = S_ACQUIRE;
                    end
                    S_ACQUIRE: begin
                        if ((w_set_new == r_set) && !w_ovf_new) begin
                            w_match_nxt = r_match + MW'(1);
                            if (w_match_nxt == LOCK_M) begin
                                w_state_nxt  = S_LOCKED;
                                w_locked_nxt = 1'b1;
                            end
                        end else begin
                            w_match_nxt = MW'(1);
                        end
                    end
                    S_LOCKED: begin
                        if ((w_set_new != r_set) || w_ovf_new) begin
                            w_locked_nxt = 1'b0;
                            w_match_nxt  = MW'(1);
                            w_state_nxt  = S_ACQUIRE;
                        end
                    end
                    default: begin
                        w_state_nxt  = S_UNLOCKED;
                        w_match_nxt  = '0;
                        w_locked_nxt = 1'b0;
                    end
                endcase
            end
        end
    end

    assign width       = r_set[SET_W-1      -: CW];
    assign height      = r_set[SET_W-1-CW   -: CW];
    assign h_total     = r_set[SET_W-1-2*CW -: CW];
    assign v_total     = r_set[SET_W-1-3*CW -: CW];
`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
    assign hsync_width = r_set[SET_W-1-4*CW -: CW];
    assign vsync_width = r_set[SET_W-1-5*CW -: CW];
`endif
    assign locked      = r_locked;
    assign overflow    = r_ovf;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule

// File: tb/tb_video_timing_analyser.sv
// tb_video_timing_analyser
//   Directed bench: a background generator produces a small raster
//   (24 px/line, 18 active, 10 lines, 7 active, vid_clk = clk/4) with
//   hsync and vsync falling on the same pixel at each frame start.
module tb_video_timing_analyser;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_clk, vid_hsync_n, vid_vsync_n, vid_hblank_n, vid_vblank_n;
    logic [CW-1:0] width, height, h_total, v_total;
`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
    logic [CW-1:0] hsync_width, vsync_width;
`endif
    logic          locked, frame_start, line_start, overflow;

    int checks = 0;
    int errors = 0;

    // generator controls, latched at each frame start
    int g_ht = 24, g_aw = 18, g_vt = 10, g_ah = 7;
    bit g_run = 1'b1, g_idle = 1'b0;
    int f_ht, f_aw, f_vt, f_ah;

    video_timing_analyser #(
        .COUNT_WIDTH (CW),
        .LOCK_FRAMES (3),
        .SYNC_STAGES (2),
        .TIMEOUT_BITS(12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vid_clk     (vid_clk),
        .vid_hsync_n (vid_hsync_n),
        .vid_vsync_n (vid_vsync_n),
        .vid_hblank_n(vid_hblank_n),
        .vid_vblank_n(vid_vblank_n),
        .width       (width),
        .height      (height),
        .h_total     (h_total),
        .v_total     (v_total),
`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
        .hsync_width (hsync_width),
        .vsync_width (vsync_width),
`endif
        .locked      (locked),
        .frame_start (frame_start),
        .line_start  (line_start),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // wait for the next frame_start, counting line_start pulses on the way
    task automatic wait_fs(input int budget, output int lines);
        bit found;
        found = 1'b0;
        lines = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (line_start)  lines++;
            if (frame_start) found = 1'b1;
        end
        check_value("fs_seen", {63'd0, found}, 64'd1);
    endtask

    function automatic logic [63:0] geom();
        geom = {16'd0, width, height, h_total, v_total};
    endfunction

    function automatic logic [63:0] all_outs();
        all_outs = {12'd0, width, height, h_total, v_total, locked, overflow, frame_start, line_start};
    endfunction

    // raster generator: data changes with vid_clk low, stable across its rising edge
    initial begin
        vid_clk = 1'b0; vid_hsync_n = 1'b1; vid_vsync_n = 1'b1;
        vid_hblank_n = 1'b1; vid_vblank_n = 1'b1;
        forever begin
            while (!g_run) begin
                g_idle  = 1'b1;
                vid_clk = 1'b0;
                @(negedge clk);
            end
            g_idle = 1'b0;
            f_ht = g_ht; f_aw = g_aw; f_vt = g_vt; f_ah = g_ah;
            for (int ln = 0; ln < f_vt; ln++) begin
                for (int px = 0; px < f_ht; px++) begin
                    vid_clk      = 1'b0;
                    vid_hsync_n  = (px >= 2);
                    vid_vsync_n  = !(ln == 0 && px < 4);
                    vid_hblank_n = (px < f_aw);
                    vid_vblank_n = (ln < f_ah);
                    repeat (2) @(negedge clk);
                    vid_clk = 1'b1;
                    repeat (2) @(negedge clk);
                end
            end
        end
    end

    initial begin
        int  nl;
        bit  seen;
        // power-on reset
        repeat (5) @(negedge clk);
        check_value("por_outs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // acquire lock on the nominal raster
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            wait_fs(1200, nl);
            seen = locked;
        end
        check_value("por_lock", {63'd0, locked}, 64'd1);
        check_value("por_geom", geom(), {16'd0, 12'd18, 12'd7, 12'd24, 12'd10});
        check_value("por_ovf", {63'd0, overflow}, 64'd0);
`ifdef VIDEO_TIMING_SYNC_WIDTH_EN
        check_value("hsync_w", {52'd0, hsync_width}, 64'd2);
        check_value("vsync_w", {52'd0, vsync_width}, 64'd1);
`endif
        // coincident hsync/vsync: exactly 10 line starts per frame
        wait_fs(1200, nl);
        check_value("lines_per_frame", nl, 64'd10);
        check_value("vtot_exact", {52'd0, v_total}, 64'd10);

        // asynchronous reset in the middle of a frame
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_value("async_rst", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_fs(1200, nl);
            check_value($sformatf("rst_lock_fs%0d", k), {63'd0, locked}, (k == 4) ? 64'd1 : 64'd0);
        end
        check_value("rst_geom", geom(), {16'd0, 12'd18, 12'd7, 12'd24, 12'd10});

        // one frame of 16 active pixels while locked
        g_aw = 16;
        wait_fs(1200, nl);
        check_value("chg_pre_lock", {63'd0, locked}, 64'd1);
        g_aw = 18;
        wait_fs(1200, nl);
        check_value("chg_width", {52'd0, width}, 64'd16);
        check_value("chg_drop", {63'd0, locked}, 64'd0);
        wait_fs(1200, nl);
        check_value("chg_back_width", {52'd0, width}, 64'd18);
        check_value("chg_back_lock1", {63'd0, locked}, 64'd0);
        wait_fs(1200, nl);
        check_value("chg_back_lock2", {63'd0, locked}, 64'd0);
        wait_fs(1200, nl);
        check_value("chg_relock", {63'd0, locked}, 64'd1);

        // stop vid_clk: watchdog drops lock after 4096 clk, outputs hold
        g_run = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = g_idle;
        end
        check_value("gen_idle", {63'd0, seen}, 64'd1);
        repeat (4000) @(negedge clk);
        check_value("wd_before", {63'd0, locked}, 64'd1);
        repeat (200) @(negedge clk);
        check_value("wd_after", {63'd0, locked}, 64'd0);
        repeat (800) @(negedge clk);
        check_value("wd_hold", geom(), {16'd0, 12'd18, 12'd7, 12'd24, 12'd10});

        // resume with 4097-pixel lines, one line per frame
        g_ht = 4097; g_aw = 4000; g_vt = 1; g_ah = 1;
        g_run = 1'b1;
        wait_fs(200, nl);
        check_value("ovf_discard", {52'd0, h_total}, 64'd24);
        check_value("ovf_discard_lock", {63'd0, locked}, 64'd0);
        for (int k = 2; k <= 4; k++) begin
            wait_fs(20000, nl);
            check_value($sformatf("ovf_htot_fs%0d", k), {52'd0, h_total}, 64'd4095);
            check_value($sformatf("ovf_flag_fs%0d", k), {63'd0, overflow}, 64'd1);
            check_value($sformatf("ovf_lock_fs%0d", k), {63'd0, locked}, 64'd0);
        end
        check_value("ovf_geom", geom(), {16'd0, 12'd4000, 12'd1, 12'd4095, 12'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
